// File: rtl/toy_fetch_align.sv
// rtl/toy_fetch_align.sv - splits 64-bit fetch blocks into aligned RV32/RVC instructions
package toy_pack;
  localparam int ADDR_WIDTH = 32;

  typedef struct packed {
    logic [31:0]           inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  is_cext;
    logic                  carry;
    logic [1:0]            offset;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_target;
    logic                  bypass;
  } fetch_queue_pkg;
endpackage

module toy_fetch_align #(
  parameter int ADDR_WIDTH = toy_pack::ADDR_WIDTH,
  parameter int BLK_HW     = 4,
  parameter int MUX_OUT    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cancel_en,
  input  logic                     blk_vld,
  output logic                     blk_rdy,
  input  logic [ADDR_WIDTH-1:0]    blk_pc,
  input  logic [63:0]              blk_data,
  output logic                     req_vld,
  input  logic                     req_rdy,
  output toy_pack::fetch_queue_pkg v_req_pld [MUX_OUT],
  output logic [MUX_OUT-1:0]       v_req_en
);

  typedef struct packed {
    logic                     ok;
    logic [2:0]               len;
    toy_pack::fetch_queue_pkg pld;
  } slot_t;

  logic                  hb_vld;
  logic [63:0]           hb_data;
  logic [ADDR_WIDTH-1:0] hb_pc_base;
  logic [2:0]            hb_idx;
  logic                  cr_vld;
  logic [15:0]           cr_hw;
  logic [ADDR_WIDTH-1:0] cr_pc;

  slot_t       s0, s1;
  logic        en1, fire, retire, accept;
  logic [2:0]  idx_post;
  logic [15:0] hw3;
  logic        unused_pc0;

  assign hw3        = hb_data[63:48];
  assign unused_pc0 = blk_pc[0];

  function automatic logic [15:0] hw_at(input logic [63:0] d, input logic [1:0] k);
    return d[{k, 4'b0000} +: 16];
  endfunction

  // Position p beyond the block, or a low half at hw3, yields an empty slot.
  function automatic slot_t decode(input logic [63:0] d, input logic [ADDR_WIDTH-1:0] base,
                                   input logic [2:0] p);
    slot_t       s;
    logic [15:0] lo;
    logic [15:0] hi;
    s  = '0;
    lo = hw_at(d, p[1:0]);
    hi = hw_at(d, p[1:0] + 2'd1);
    if (p < 3'd4) begin
      s.pld.pc     = base + ADDR_WIDTH'({p, 1'b0});
      s.pld.offset = p[1:0];
      if (lo[1:0] != 2'b11) begin
        s.ok          = 1'b1;
        s.len         = 3'd1;
        s.pld.inst    = {16'h0000, lo};
        s.pld.is_cext = 1'b1;
      end else if (p != 3'd3) begin
        s.ok       = 1'b1;
        s.len      = 3'd2;
        s.pld.inst = {hi, lo};
      end
    end
    return s;
  endfunction

  always_comb begin
    s0 = '0;
    if (cr_vld) begin
      s0.ok         = 1'b1;
      s0.len        = 3'd1;
      s0.pld.inst   = {hw_at(hb_data, 2'd0), cr_hw};
      s0.pld.pc     = cr_pc;
      s0.pld.carry  = 1'b1;
      s0.pld.offset = 2'd3;
    end else begin
      s0 = decode(hb_data, hb_pc_base, hb_idx);
    end
    s1       = decode(hb_data, hb_pc_base, hb_idx + s0.len);
    req_vld  = hb_vld && s0.ok;
    en1      = req_vld && s1.ok;
    fire     = req_vld && req_rdy && !cancel_en;
    idx_post = fire ? (hb_idx + s0.len + (en1 ? s1.len : 3'd0)) : hb_idx;
    retire   = hb_vld && ((idx_post == 3'(BLK_HW)) || (idx_post == 3'd3 && hw3[1:0] == 2'b11));
    blk_rdy  = !cancel_en && (!hb_vld || retire);
    accept   = blk_vld && blk_rdy;
  end

  always_comb begin
    v_req_en     = {en1, req_vld};
    v_req_pld[0] = req_vld ? s0.pld : '0;
    v_req_pld[1] = en1 ? s1.pld : '0;
  end

  // Ordering matters: a same-cycle accept overrides retire, which overrides fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_vld     <= 1'b0;
      hb_data    <= '0;
      hb_pc_base <= '0;
      hb_idx     <= 3'd0;
      cr_vld     <= 1'b0;
      cr_hw      <= '0;
      cr_pc      <= '0;
    end else if (cancel_en) begin
      hb_vld <= 1'b0;
      cr_vld <= 1'b0;
      hb_idx <= 3'd0;
    end else begin
      if (fire) begin
        hb_idx <= idx_post;
        if (cr_vld) cr_vld <= 1'b0;
      end
      if (retire) begin
        hb_vld <= 1'b0;
        if (idx_post == 3'd3) begin
          cr_vld <= 1'b1;
          cr_hw  <= hw3;
          cr_pc  <= hb_pc_base + ADDR_WIDTH'(6);
        end
      end
      if (accept) begin
        hb_vld     <= 1'b1;
        hb_data    <= blk_data;
        hb_pc_base <= {blk_pc[ADDR_WIDTH-1:3], 3'b000};
        hb_idx     <= {1'b0, blk_pc[2:1]};
        if (blk_pc[2:1] != 2'd0) cr_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toy_fetch_align.sv
// tb/tb_toy_fetch_align.sv - directed and randomized checks of toy_fetch_align
module tb_toy_fetch_align;
  localparam int AW = toy_pack::ADDR_WIDTH;
  typedef toy_pack::fetch_queue_pkg pld_t;
  typedef struct {
    logic [15:0]   hw;
    logic [AW-1:0] pc;
    logic [1:0]    off;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cancel_en = 1'b0;
  logic          blk_vld = 1'b0;
  logic          blk_rdy;
  logic [AW-1:0] blk_pc = '0;
  logic [63:0]   blk_data = '0;
  logic          req_vld;
  logic          req_rdy = 1'b1;
  pld_t          v_req_pld [2];
  logic [1:0]    v_req_en;

  int total = 0;
  int bad = 0;

  toy_fetch_align dut (
    .clk(clk), .rst_n(rst_n), .cancel_en(cancel_en),
    .blk_vld(blk_vld), .blk_rdy(blk_rdy), .blk_pc(blk_pc), .blk_data(blk_data),
    .req_vld(req_vld), .req_rdy(req_rdy), .v_req_pld(v_req_pld), .v_req_en(v_req_en)
  );

  always #5 clk = ~clk;

  // Reference model: pending halfwords of the held block as a queue, plus the carry.
  bit            mb_vld = 0;
  ent_t          mq[$];
  bit            mc_vld = 0;
  logic [15:0]   mc_hw = '0;
  logic [AW-1:0] mc_pc = '0;

  bit         e_vld, e_cr, e_fire, e_ret, e_rdy, e_acc;
  logic [1:0] e_en;
  pld_t       e_pld [2];
  int         e_take;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] blk4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic model_eval();
    int   take;
    bit   stop;
    pld_t p;
    int   rem;
    e_en = 2'b00; e_pld[0] = '0; e_pld[1] = '0; take = 0; e_cr = 0; stop = 0;
    if (mb_vld) begin
      for (int s = 0; s < 2; s++) begin
        if (!stop) begin
          p = '0;
          if (s == 0 && mc_vld) begin
            p.inst = {mq[0].hw, mc_hw}; p.pc = mc_pc; p.carry = 1'b1; p.offset = 2'd3;
            take = 1; e_cr = 1;
          end else if (take < mq.size() && mq[take].hw[1:0] != 2'b11) begin
            p.inst = {16'h0000, mq[take].hw}; p.pc = mq[take].pc; p.is_cext = 1'b1;
            p.offset = mq[take].off; take += 1;
          end else if (take + 1 < mq.size()) begin
            p.inst = {mq[take+1].hw, mq[take].hw}; p.pc = mq[take].pc;
            p.offset = mq[take].off; take += 2;
          end else begin
            stop = 1;
          end
          if (!stop) begin
            e_en[s] = 1'b1;
            e_pld[s] = p;
          end
        end
      end
    end
    e_vld  = e_en[0];
    e_take = take;
    e_fire = e_vld && req_rdy && !cancel_en;
    rem    = mq.size() - (e_fire ? e_take : 0);
    e_ret  = mb_vld && (rem == 0 || (rem == 1 && mq[mq.size()-1].hw[1:0] == 2'b11 &&
                                     !(mc_vld && !(e_fire && e_cr))));
    e_rdy  = !cancel_en && (!mb_vld || e_ret);
    e_acc  = blk_vld && e_rdy;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    chk("req_vld", 128'(req_vld), 128'(e_vld));
    chk("v_req_en", 128'(v_req_en), 128'(e_en));
    chk("blk_rdy", 128'(blk_rdy), 128'(e_rdy));
    if (e_en[0]) chk("pld0", 128'(v_req_pld[0]), 128'(e_pld[0]));
    if (e_en[1]) chk("pld1", 128'(v_req_pld[1]), 128'(e_pld[1]));
  endtask

  task automatic advance();
    ent_t e;
    if (cancel_en) begin
      mb_vld = 0; mq.delete(); mc_vld = 0;
    end else begin
      if (e_fire) begin
        repeat (e_take) void'(mq.pop_front());
        if (e_cr) mc_vld = 0;
      end
      if (e_ret) begin
        if (mq.size() == 1) begin
          mc_vld = 1; mc_hw = mq[0].hw; mc_pc = mq[0].pc;
        end
        mq.delete();
        mb_vld = 0;
      end
      if (e_acc) begin
        mb_vld = 1;
        mq.delete();
        for (int k = int'(blk_pc[2:1]); k < 4; k++) begin
          e.hw  = blk_data[16*k +: 16];
          e.pc  = {blk_pc[AW-1:3], 3'b000} + AW'(2 * k);
          e.off = 2'(k);
          mq.push_back(e);
        end
        if (blk_pc[2:1] != 2'd0) mc_vld = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic send_blk(input logic [AW-1:0] pc, input logic [63:0] d);
    bit got;
    got = 0;
    blk_vld = 1'b1; blk_pc = pc; blk_data = d;
    for (int i = 0; i < 20 && !got; i++) begin
      sample();
      got = e_acc;
      advance();
    end
    blk_vld = 1'b0;
    chk("send_accept", 128'(got), 128'(1));
  endtask

  initial begin
    logic [AW-1:0] seq_pc;
    logic [31:0]   r;
    logic [63:0]   d;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_vld", 128'(req_vld), 128'(0));
    chk("rst_en", 128'(v_req_en), 128'(0));
    chk("rst_blk_rdy", 128'(blk_rdy), 128'(1));
    chk("rst_pld0", 128'(v_req_pld[0]), 128'(0));
    chk("rst_pld1", 128'(v_req_pld[1]), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(2);

    // four RVC
    send_blk(32'h1000, blk4(16'h0001, 16'h0001, 16'h0001, 16'h0001));
    sample();
    chk("t1_pc0", 128'(v_req_pld[0].pc), 128'(32'h1000));
    chk("t1_pc1", 128'(v_req_pld[1].pc), 128'(32'h1002));
    advance();
    sample();
    chk("t1_c2_pc1", 128'(v_req_pld[1].pc), 128'(32'h1006));
    chk("t1_c2_rdy", 128'(blk_rdy), 128'(1));
    advance();
    run(2);

    // two 32-bit
    send_blk(32'h2000, {32'h0000_0013, 32'h0000_0013});
    sample();
    chk("t2_en", 128'(v_req_en), 128'(2'b11));
    chk("t2_pc1", 128'(v_req_pld[1].pc), 128'(32'h2004));
    chk("t2_cext1", 128'(v_req_pld[1].is_cext), 128'(0));
    advance();
    run(2);

    // straddling instruction carried into the next block
    send_blk(32'h3000, blk4(16'h0001, 16'h0001, 16'h0001, 16'h0013));
    send_blk(32'h3008, blk4(16'h0000, 16'h0001, 16'h0001, 16'h0001));
    sample();
    chk("t3_inst", 128'(v_req_pld[0].inst), 128'(32'h0000_0013));
    chk("t3_pc", 128'(v_req_pld[0].pc), 128'(32'h3006));
    chk("t3_carry", 128'(v_req_pld[0].carry), 128'(1));
    advance();
    run(4);

    // start at hw2
    send_blk(32'h4004, blk4(16'hffff, 16'hffff, 16'h0001, 16'h0001));
    sample();
    chk("t4_off0", 128'(v_req_pld[0].offset), 128'(2));
    chk("t4_off1", 128'(v_req_pld[1].offset), 128'(3));
    chk("t4_pc1", 128'(v_req_pld[1].pc), 128'(32'h4006));
    advance();
    run(2);

    // back-pressure mid-block
    send_blk(32'h1100, blk4(16'h0001, 16'h0005, 16'h0009, 16'h000d));
    run(1);
    req_rdy = 1'b0;
    run(3);
    req_rdy = 1'b1;
    run(3);

    // cancel with a carry and a held block
    send_blk(32'h5000, blk4(16'h0001, 16'h0001, 16'h0001, 16'h0013));
    send_blk(32'h5008, blk4(16'h0000, 16'h0001, 16'h0001, 16'h0001));
    cancel_en = 1'b1;
    run(1);
    cancel_en = 1'b0;
    sample();
    chk("t6_req_vld", 128'(req_vld), 128'(0));
    advance();
    send_blk(32'h5008, blk4(16'h0001, 16'h0001, 16'h0001, 16'h0001));
    sample();
    chk("t6_carry", 128'(v_req_pld[0].carry), 128'(0));
    chk("t6_pc", 128'(v_req_pld[0].pc), 128'(32'h5008));
    advance();
    run(3);

    // randomized traffic
    seq_pc = 32'h8000;
    for (int c = 0; c < 400; c++) begin
      req_rdy   = ($urandom_range(3) != 0);
      cancel_en = ($urandom_range(31) == 0);
      blk_vld   = ($urandom_range(2) != 0);
      blk_pc    = seq_pc;
      if ($urandom_range(3) == 0) blk_pc = seq_pc + AW'(2 * $urandom_range(1, 3));
      for (int k = 0; k < 4; k++) begin
        r = $urandom;
        d[16*k +: 16] = {r[15:2], ($urandom_range(1) == 1) ? 2'b11 : r[1:0]};
      end
      blk_data = d;
      sample();
      if (e_acc) seq_pc = seq_pc + AW'(8);
      advance();
    end
    cancel_en = 1'b0;
    blk_vld   = 1'b0;
    req_rdy   = 1'b1;
    run(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/toy_fetch_align.md
Name: toy_fetch_align

Overview:
- Instruction aligner between the I-cache fetch-block output and the fetch buffer.
- Accepts one 64-bit fetch block (four halfwords) per handshake and splits it into RV32 standard (32-bit) and RVC (16-bit) instructions.
- Emits up to two aligned instructions per cycle on the fetch-buffer write interface.
- Carries the lower half of a 32-bit instruction that straddles two sequential blocks.

Parameters:
- ADDR_WIDTH, toy_pack::ADDR_WIDTH, PC width.
- BLK_HW, 4, halfwords per fetch block; fixed at 4 in this revision.
- MUX_OUT, 2, instruction slots per cycle; must match the fetch buffer MUX_IN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cancel_en  in  1  flush; drops the held block and the carry.
- blk_vld  in  1  fetch block valid.
- blk_rdy  out  1  aligner can accept a block this cycle.
- blk_pc  in  ADDR_WIDTH  PC of first valid halfword. Bits [2:1] give the start halfword; bit 0 is always 0.
- blk_data  in  64  halfword k is bits [16k+15:16k].
- req_vld  out  1  to fetch buffer; at least one slot valid.
- req_rdy  in  1  from fetch buffer.
- v_req_pld  out  fetch_queue_pkg[MUX_OUT]  per-slot payload.
- v_req_en  out  MUX_OUT  slot enables; contiguous from slot 0.

Behaviour:
- State registers: held block (hb_vld, hb_data, hb_pc_base = blk_pc with bits [2:0] cleared, hb_idx 3-bit 0..4) and carry (cr_vld, cr_hw 16b, cr_pc).
- Reset values: hb_vld=0, hb_idx=0, cr_vld=0, cr_hw=0, cr_pc=0.
- Reset output values: req_vld=0, v_req_en=0, blk_rdy=1, v_req_pld all zero.
- Accept: blk_vld && blk_rdy loads hb_data and hb_pc_base, and sets hb_idx = blk_pc[2:1].
  - If cr_vld and blk_pc[2:1]!=0, the carry is dropped (cr_vld<=0).
- Latency: instructions from a block accepted in cycle N are offered no earlier than cycle N+1.
- Decode rule: a halfword with bits [1:0]!=2'b11 is RVC; otherwise it is the low half of a 32-bit instruction.
- Slot extraction, combinational from registered state, slot0 first, then slot1 from the next position:
  - If cr_vld: slot0 = {hb_data hw0, cr_hw}, pc=cr_pc, is_cext=0, carry=1. Consumes hw0.
  - Otherwise, at position p:
    - RVC: inst={16'h0, hw}, pc=hb_pc_base+2p, is_cext=1, consumes 1 halfword.
    - 32-bit with p<=2: inst={hw[p+1], hw[p]}, is_cext=0, consumes 2 halfwords.
    - 32-bit with p==3: not emitted; becomes the carry candidate.
  - offset field = starting halfword index p; for the carry slot, offset = 3 (from the previous block).
  - All other bypass/prediction fields are zero.
- req_vld = hb_vld && (slot0 emittable). v_req_en[0]=req_vld; v_req_en[1] = slot1 emittable.
- Fire (req_vld && req_rdy):
  - hb_idx advances by the halfwords consumed by the enabled slots.
  - cr_vld clears if slot0 used the carry.
- Exhaustion: the block retires (hb_vld<=0) when either
  - hb_idx reaches 4, or
  - the only remaining content is a 32-bit low half at index 3. Then cr_hw<=hw3, cr_pc<=hb_pc_base+6, cr_vld<=1.
  - A block holding only a pending low half retires the cycle after acceptance with req_vld=0.
- blk_rdy = !cancel_en && (!hb_vld || retiring this cycle). Back-to-back accept on the retire cycle is required.
- req_rdy=0: slots, payload and state are held stable; no advance.
- cancel_en has priority over everything:
  - Next cycle: hb_vld=0, cr_vld=0, hb_idx=0.
  - No block is accepted and no fire is counted in the cancel cycle.
- PC arithmetic is modulo 2^ADDR_WIDTH.
- A new block after a carry is assumed sequential; redirects must arrive with cancel_en.

Test Plan:
- Four RVC (hw=16'h0001), blk_pc=0x1000 -> cycle1 en=2'b11, pc 0x1000/0x1002; cycle2 en=2'b11, pc 0x1004/0x1006. blk_rdy high in cycle2.
- Two 32-bit (0x00000013 ×2), blk_pc=0x2000 -> one cycle, en=2'b11, pc 0x2000/0x2004, is_cext=0/0.
- Block with RVC at hw0, RVC at hw1, RVC at hw2, 32-bit low half (hw3=16'h0013) at 0x3000, then block 0x3008 with hw0=16'h0000 ->
  - first beat: en=11 (0x3000, 0x3002);
  - second beat: en=01 (0x3004), carry captured;
  - next block: slot0 inst=0x00000013, pc=0x3006, carry=1.
- blk_pc=0x4004 (start hw2), two RVC -> single beat, en=11, pc 0x4004/0x4006, offsets 2/3.
- req_rdy=0 for 3 cycles mid-block -> v_req_en and payload constant, blk_rdy=0; resumes unchanged.
- cancel_en with cr_vld=1 and a held block -> next cycle req_vld=0, cr_vld=0. A new block at 0x5008 emits with carry=0.
